// File: rtl/ram_arb_pkg.sv
// Shared widths and FSM encoding for the download/CPU SDRAM arbiter.
package ram_arb_pkg;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DL_WR   = 2'd1,
    ST_CPU_ACC = 2'd2,
    ST_DRAIN   = 2'd3
  } arb_state_e;
endpackage

// File: rtl/ram_arbiter_dl_wbuf.sv
// One-entry holding register for a download write waiting for the memory port.
module dl_wbuf
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_i,
  input  logic              release_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);
  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Capture wins over release so a freed slot can be refilled in the same cycle.
  always_comb begin
    full_d = full_q;
    if (capture_i)      full_d = 1'b1;
    else if (release_i) full_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (capture_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

// File: rtl/ram_arbiter.sv
// Shares one SDRAM command port between the hps_io ROM loader and the CPU;
// the loader has priority and the CPU is stalled for the whole download.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BIOS_BASE    = 25'h0000000,
  parameter logic [5:0]        DL_INDEX_MAX = 6'h01
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  output logic              ioctl_wait,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_be,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dl_active,
  output logic              dl_done,
  output logic [23:0]       dl_words,
  output logic              dl_ovf
);
  arb_state_e        state_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        mem_be_q;
  logic              dl_valid, dl_valid_q, dl_rise, dl_fall;
  logic              dl_active_q, dl_done_q, dl_ovf_q;
  logic [23:0]       dl_words_q, dl_words_d;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              buf_full, buf_capture, buf_release;
  logic [ADDR_W-1:0] buf_addr, buf_addr_in;
  logic [DATA_W-1:0] buf_data;
  logic              idx_unused;

  assign idx_unused  = &{1'b0, ioctl_index[7:6]};
  assign dl_valid    = ioctl_download & (ioctl_index[5:0] <= DL_INDEX_MAX);
  assign dl_rise     = dl_valid & ~dl_valid_q;
  assign dl_fall     = dl_active_q & ~dl_valid & ~buf_full & (state_q == ST_IDLE);
  assign buf_release = (state_q == ST_DL_WR) & mem_ack;
  assign buf_capture = ioctl_wr & dl_valid & (~buf_full | buf_release);
  assign buf_addr_in = ioctl_addr + BIOS_BASE;

  dl_wbuf u_wbuf (
    .clk       (clk_sys),
    .rst       (reset),
    .capture_i (buf_capture),
    .release_i (buf_release),
    .addr_i    (buf_addr_in),
    .data_i    (ioctl_dout),
    .full_o    (buf_full),
    .addr_o    (buf_addr),
    .data_o    (buf_data)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (buf_full) begin
            state_q     <= ST_DL_WR;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_be_q    <= 2'b11;
            mem_addr_q  <= buf_addr;
            mem_wdata_q <= buf_data;
          end else if (cpu_req && !dl_active_q) begin
            state_q     <= ST_CPU_ACC;
            mem_req_q   <= 1'b1;
            mem_we_q    <= cpu_we;
            mem_be_q    <= cpu_be;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
          end
        end
        ST_DL_WR, ST_CPU_ACC: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dl_words_d = dl_words_q;
    if (dl_rise)                                  dl_words_d = '0;
    else if (buf_release && dl_words_q != '1)     dl_words_d = dl_words_q + 24'd1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_valid_q  <= 1'b0;
      dl_active_q <= 1'b0;
      dl_done_q   <= 1'b0;
      dl_ovf_q    <= 1'b0;
      dl_words_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      dl_valid_q <= dl_valid;
      dl_done_q  <= dl_fall;
      dl_words_q <= dl_words_d;
      if (dl_rise)      dl_active_q <= 1'b1;
      else if (dl_fall) dl_active_q <= 1'b0;
      if (ioctl_wr && dl_valid && buf_full && !buf_release) dl_ovf_q <= 1'b1;
      if (cpu_ack) cpu_rdata_q <= mem_rdata;
    end
  end

  // Read data bypasses the holding register in the ack cycle so it is valid with cpu_ack.
  assign cpu_ack    = (state_q == ST_CPU_ACC) & mem_ack;
  assign cpu_rdata  = cpu_ack ? mem_rdata : cpu_rdata_q;
  assign ioctl_wait = ~reset & (buf_full | (ioctl_wr & dl_valid));

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign dl_active = dl_active_q;
  assign dl_done   = dl_done_q;
  assign dl_words  = dl_words_q;
  assign dl_ovf    = dl_ovf_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed + randomized checks of ram_arbiter against a fake SDRAM and an
// event log of completed memory commands, CPU acks and download-done pulses.
module tb_ram_arbiter;
  localparam logic [24:0] BASE = 25'h0100000;

  typedef struct {
    int          kind;  // 0 = mem command done, 1 = cpu_ack, 2 = dl_done
    logic        we;
    logic [24:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } ev_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0, ioctl_wait;
  logic [7:0]  ioctl_index = 8'h0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
  logic [24:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0, cpu_rdata;
  logic [1:0]  cpu_be = 2'b11;
  logic        mem_req, mem_we, mem_ack;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata = '0;
  logic [1:0]  mem_be;
  logic        dl_active, dl_done, dl_ovf;
  logic [23:0] dl_words;

  logic        resp_ack = 1'b0, man_ack = 1'b0, resp_en = 1'b1;
  int          lat = 3, cnt = 0, done_cnt = 0, cpu_ack_cnt = 0;
  int          errors = 0, checks = 0;
  logic [15:0] cur;
  logic [15:0] fake_mem [logic [24:0]];
  logic [15:0] model_mem [logic [24:0]];
  ev_t         ev_q [$];

  assign mem_ack = resp_ack | man_ack;
  always #5 clk = ~clk;

  ram_arbiter #(.BIOS_BASE(BASE), .DL_INDEX_MAX(6'h01)) dut (
    .clk_sys(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dl_active(dl_active), .dl_done(dl_done), .dl_words(dl_words), .dl_ovf(dl_ovf)
  );

  function automatic ev_t mk_ev(int k, logic we, logic [24:0] a, logic [15:0] d, logic [1:0] be);
    ev_t e;
    e.kind = k; e.we = we; e.addr = a; e.data = d; e.be = be;
    return e;
  endfunction

  // Fake SDRAM: acks `lat` cycles into a request, logs completions mid-cycle.
  always @(negedge clk) begin
    if (dl_done) begin
      ev_q.push_back(mk_ev(2, 1'b0, '0, '0, '0));
      done_cnt++;
    end
    if (reset) begin
      cnt = 0; resp_ack = 1'b0;
    end else if (resp_ack) begin
      resp_ack = 1'b0;
    end else if (mem_req && resp_en) begin
      cnt++;
      if (cnt >= lat) begin
        cnt = 0;
        cur = fake_mem.exists(mem_addr) ? fake_mem[mem_addr] : 16'h0;
        if (mem_we) begin
          if (mem_be[0]) cur[7:0]  = mem_wdata[7:0];
          if (mem_be[1]) cur[15:8] = mem_wdata[15:8];
          fake_mem[mem_addr] = cur;
          ev_q.push_back(mk_ev(0, 1'b1, mem_addr, mem_wdata, mem_be));
        end else begin
          mem_rdata = cur;
          ev_q.push_back(mk_ev(0, 1'b0, mem_addr, cur, mem_be));
        end
        resp_ack = 1'b1;
        #1;
        if (cpu_ack) begin
          ev_q.push_back(mk_ev(1, 1'b0, '0, cpu_rdata, '0));
          cpu_ack_cnt++;
        end
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_ev(input string tag, input int kind, input logic we, input logic [24:0] a,
                        input logic [15:0] d, input logic [1:0] be, input bit chk_data);
    ev_t e;
    chk({tag, "_present"}, 64'(ev_q.size() > 0), 64'd1);
    if (ev_q.size() == 0) return;
    e = ev_q.pop_front();
    chk({tag, "_kind"}, 64'(e.kind), 64'(kind));
    if (e.kind != kind) return;
    if (kind == 0) begin
      chk({tag, "_we"}, 64'(e.we), 64'(we));
      chk({tag, "_addr"}, 64'(e.addr), 64'(a));
      chk({tag, "_be"}, 64'(e.be), 64'(be));
    end
    if (chk_data) chk({tag, "_data"}, 64'(e.data), 64'(d));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic dl_write(input logic [24:0] a, input logic [15:0] d, input bit chk_wait);
    int n = 0;
    while (ioctl_wait && n < 300) begin tick(); n++; end
    chk("dl_wr_wait_bound", 64'(n < 300), 64'd1);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    #1;
    if (chk_wait) chk("wait_in_wr_cycle", 64'(ioctl_wait), 64'd1);
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 300) begin tick(); n++; end
    chk("dl_done_bound", 64'(n < 300), 64'd1);
    tick();
  endtask

  task automatic cpu_op(input string tag, input logic we, input logic [24:0] a,
                        input logic [15:0] d, input logic [1:0] be, input logic [15:0] exp_rd);
    int n = 0;
    int c0 = cpu_ack_cnt;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be; cpu_req = 1'b1;
    while (cpu_ack_cnt == c0 && n < 300) begin tick(); n++; end
    chk({tag, "_ack_bound"}, 64'(n < 300), 64'd1);
    cpu_req = 1'b0;
    exp_ev(tag, 0, we, a, we ? d : exp_rd, be, 1'b1);
    exp_ev({tag, "_ack"}, 1, 1'b0, '0, exp_rd, '0, !we);
  endtask

  task automatic do_reset();
    ioctl_download = 1'b0; ioctl_wr = 1'b0; cpu_req = 1'b0; man_ack = 1'b0; resp_en = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    ev_q.delete();
  endtask

  initial begin
    logic [24:0] a, xa;
    logic [15:0] d, v, w;
    logic [1:0]  be;
    logic        we;
    logic [24:0] exp_a [$];
    logic [15:0] exp_d [$];
    int          d0, nwr;
    bit          seen;

    // Reset state
    repeat (2) tick();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_ioctl_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    chk("rst_dl_flags", 64'({dl_active, dl_done, dl_ovf}), 64'd0);
    chk("rst_dl_words", 64'(dl_words), 64'd0);
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_mem_fields", 64'({mem_we, mem_addr, mem_wdata, mem_be}), 64'd0);
    reset = 1'b0;
    tick();

    // Basic download of three words
    ioctl_index = 8'h01; ioctl_download = 1'b1; lat = 3;
    tick(); tick();
    chk("basic_dl_active", 64'(dl_active), 64'd1);
    d0 = done_cnt;
    dl_write(25'h0, 16'h1111, 1'b1);
    dl_write(25'h2, 16'h2222, 1'b1);
    dl_write(25'h4, 16'h3333, 1'b1);
    ioctl_download = 1'b0;
    wait_done(d0);
    repeat (3) tick();
    exp_ev("basic_w0", 0, 1'b1, BASE + 25'h0, 16'h1111, 2'b11, 1'b1);
    exp_ev("basic_w1", 0, 1'b1, BASE + 25'h2, 16'h2222, 2'b11, 1'b1);
    exp_ev("basic_w2", 0, 1'b1, BASE + 25'h4, 16'h3333, 2'b11, 1'b1);
    exp_ev("basic_done", 2, 1'b0, '0, '0, '0, 1'b0);
    chk("basic_words", 64'(dl_words), 64'd3);
    chk("basic_done_once", 64'(done_cnt - d0), 64'd1);
    chk("basic_inactive", 64'(dl_active), 64'd0);
    chk("basic_wait_low", 64'(ioctl_wait), 64'd0);

    // ioctl_wr in the same cycle as the buffered write's mem_ack; address wraps
    ioctl_index = 8'hC0; ioctl_download = 1'b1; lat = 3; d0 = done_cnt;
    tick();
    dl_write(25'h10, 16'hA5A5, 1'b0);
    nwr = 0;
    while (!mem_ack && nwr < 50) begin @(negedge clk); #2; nwr++; end
    chk("simul_ack_bound", 64'(nwr < 50), 64'd1);
    ioctl_addr = 25'h1FFFFFE; ioctl_dout = 16'h5A5A; ioctl_wr = 1'b1;
    #1;
    chk("simul_wait_high", 64'(ioctl_wait), 64'd1);
    tick();
    ioctl_wr = 1'b0;
    chk("simul_wait_held", 64'(ioctl_wait), 64'd1);
    ioctl_download = 1'b0;
    wait_done(d0);
    exp_ev("simul_w0", 0, 1'b1, BASE + 25'h10, 16'hA5A5, 2'b11, 1'b1);
    exp_ev("simul_w1", 0, 1'b1, 25'h00FFFFE, 16'h5A5A, 2'b11, 1'b1);
    exp_ev("simul_done", 2, 1'b0, '0, '0, '0, 1'b0);
    chk("simul_no_ovf", 64'(dl_ovf), 64'd0);
    chk("simul_words", 64'(dl_words), 64'd2);

    // Randomized download
    ioctl_index = {2'($urandom), 6'($urandom_range(0, 1))};
    ioctl_download = 1'b1; d0 = done_cnt;
    tick();
    a = 25'($urandom) & ~25'h1;
    for (int k = 0; k < 6; k++) begin
      lat = $urandom_range(1, 4);
      d = 16'($urandom);
      exp_a.push_back(a + BASE);
      exp_d.push_back(d);
      dl_write(a, d, 1'b1);
      a = a + 25'h2;
    end
    ioctl_download = 1'b0;
    wait_done(d0);
    for (int k = 0; k < 6; k++) exp_ev("rnd_dl", 0, 1'b1, exp_a[k], exp_d[k], 2'b11, 1'b1);
    exp_ev("rnd_dl_done", 2, 1'b0, '0, '0, '0, 1'b0);
    chk("rnd_dl_words", 64'(dl_words), 64'd6);

    // Index filter
    ioctl_index = 8'h02; ioctl_download = 1'b1;
    tick();
    ioctl_addr = 25'h20; ioctl_dout = 16'hDEAD; ioctl_wr = 1'b1;
    #1;
    chk("filt_wait", 64'(ioctl_wait), 64'd0);
    tick();
    ioctl_wr = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin seen |= mem_req | dl_active; tick(); end
    chk("filt_no_req_no_active", 64'(seen), 64'd0);
    ioctl_download = 1'b0;
    tick();

    // CPU read with no download
    fake_mem[25'h0000100] = 16'hBEEF;
    model_mem[25'h0000100] = 16'hBEEF;
    lat = 3;
    cpu_op("cpu_rd_beef", 1'b0, 25'h0000100, 16'h0, 2'b11, 16'hBEEF);
    repeat (2) tick();
    chk("cpu_rdata_hold", 64'(cpu_rdata), 64'hBEEF);

    // Randomized CPU traffic against a byte-merge memory model
    for (int k = 0; k < 12; k++) begin
      lat = $urandom_range(1, 5);
      xa = 25'h0080000 + 25'(2 * $urandom_range(0, 7));
      we = 1'($urandom);
      be = 2'($urandom_range(1, 3));
      d = 16'($urandom);
      v = model_mem.exists(xa) ? model_mem[xa] : 16'h0;
      cpu_op("rnd_cpu", we, xa, d, be, v);
      if (we) begin
        if (be[0]) v[7:0]  = d[7:0];
        if (be[1]) v[15:8] = d[15:8];
        model_mem[xa] = v;
      end
      tick();
    end

    // Contention: download starts while a CPU read is in flight
    fake_mem[25'h0000090] = 16'h1234;
    lat = 5; d0 = done_cnt;
    cpu_we = 1'b0; cpu_addr = 25'h0000090; cpu_be = 2'b11; cpu_req = 1'b1;
    nwr = 0;
    while (!mem_req && nwr < 50) begin tick(); nwr++; end
    chk("ct_req_bound", 64'(nwr < 50), 64'd1);
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    chk("ct_dl_active", 64'(dl_active), 64'd1);
    w = 16'($urandom);
    dl_write(25'h40, 16'h0F0F, 1'b1);
    dl_write(25'h42, w, 1'b1);
    cpu_addr = BASE + 25'h42;
    ioctl_download = 1'b0;
    wait_done(d0);
    nwr = 0;
    while (cpu_ack_cnt < 0 + 1 + cpu_ack_cnt - cpu_ack_cnt && nwr < 0) nwr++;
    nwr = 0;
    while (ev_q.size() < 7 && nwr < 100) begin tick(); nwr++; end
    chk("ct_events_bound", 64'(nwr < 100), 64'd1);
    cpu_req = 1'b0;
    exp_ev("ct_cpu_rd", 0, 1'b0, 25'h0000090, 16'h1234, 2'b11, 1'b1);
    exp_ev("ct_cpu_ack", 1, 1'b0, '0, 16'h1234, '0, 1'b1);
    exp_ev("ct_dl_w0", 0, 1'b1, BASE + 25'h40, 16'h0F0F, 2'b11, 1'b1);
    exp_ev("ct_dl_w1", 0, 1'b1, BASE + 25'h42, w, 2'b11, 1'b1);
    exp_ev("ct_done", 2, 1'b0, '0, '0, '0, 1'b0);
    exp_ev("ct_cpu_rd2", 0, 1'b0, BASE + 25'h42, w, 2'b11, 1'b1);
    exp_ev("ct_cpu_ack2", 1, 1'b0, '0, w, '0, 1'b1);
    repeat (2) tick();

    // Overflow: second write ignores ioctl_wait
    do_reset();
    lat = 3; ioctl_index = 8'h01; ioctl_download = 1'b1; d0 = done_cnt;
    tick();
    dl_write(25'h30, 16'h7777, 1'b0);
    ioctl_addr = 25'h32; ioctl_dout = 16'h8888; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    wait_done(d0);
    exp_ev("ovf_w0", 0, 1'b1, BASE + 25'h30, 16'h7777, 2'b11, 1'b1);
    exp_ev("ovf_done", 2, 1'b0, '0, '0, '0, 1'b0);
    chk("ovf_flag", 64'(dl_ovf), 64'd1);
    chk("ovf_words", 64'(dl_words), 64'd1);
    repeat (4) tick();
    chk("ovf_sticky", 64'(dl_ovf), 64'd1);

    // Reset in the middle of a DL_WR
    do_reset();
    chk("ovf_cleared", 64'(dl_ovf), 64'd0);
    lat = 2; ioctl_index = 8'h01; ioctl_download = 1'b1;
    tick();
    dl_write(25'h50, 16'h1357, 1'b0);
    nwr = 0;
    while (dl_words != 24'd1 && nwr < 50) begin tick(); nwr++; end
    chk("rmid_first_word", 64'(dl_words), 64'd1);
    resp_en = 1'b0;
    dl_write(25'h52, 16'h2468, 1'b0);
    nwr = 0;
    while (!mem_req && nwr < 50) begin tick(); nwr++; end
    chk("rmid_req_up", 64'(mem_req), 64'd1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rmid_req_drop", 64'(mem_req), 64'd0);
    chk("rmid_words_zero", 64'(dl_words), 64'd0);
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    man_ack = 1'b1;
    #1;
    chk("rmid_stray_no_cpu_ack", 64'(cpu_ack), 64'd0);
    tick();
    man_ack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin seen |= mem_req | dl_active | (dl_words != 0); tick(); end
    chk("rmid_stray_ignored", 64'(seen), 64'd0);
    resp_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
